// File: rtl/res_token_emitter.sv
// Result-bundle to router-token serialiser: a small bundle FIFO feeding a
// three-state emitter that sends zero, one or two tokens per bundle.
module res_token_emitter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int GEN_W  = 12,
  parameter int NODE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] opr0_i,
  input  logic [GEN_W-1:0]  gen_i,
  input  logic              t_next_lr_i,
  input  logic              t_next_uni_opr_i,
  input  logic [NODE_W-1:0] t_next_node_i,
  input  logic              f_next_lr_i,
  input  logic              f_next_uni_opr_i,
  input  logic [NODE_W-1:0] f_next_node_i,
  input  logic              cp_i,
  input  logic              terminate_i,
  input  logic              pe_out_i,
  input  logic [2:0]        pe_num_i,
  output logic              tok_valid_o,
  input  logic              tok_ready_i,
  output logic [DATA_W-1:0] tok_data_o,
  output logic [GEN_W-1:0]  tok_gen_o,
  output logic [NODE_W-1:0] tok_node_o,
  output logic              tok_lr_o,
  output logic              tok_uni_opr_o,
  output logic              tok_pe_out_o,
  output logic [2:0]        tok_pe_num_o,
  output logic              term_o,
  output logic              busy_o,
  output logic [15:0]       tok_cnt_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] opr0;
    logic [GEN_W-1:0]  gen;
    logic              t_lr;
    logic              t_uni;
    logic [NODE_W-1:0] t_node;
    logic              f_lr;
    logic              f_uni;
    logic [NODE_W-1:0] f_node;
    logic              cp;
    logic              term;
    logic              pe_out;
    logic [2:0]        pe_num;
  } bundle_t;

  typedef enum logic [1:0] {IDLE, EMIT_T, EMIT_F} state_t;

  // Token port: tok_valid_o stays high with all fields frozen until
  // tok_valid_o && tok_ready_i is seen on a rising edge; only then may it move.
  bundle_t           r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  state_t            r_state;
  logic              r_tok_valid;
  logic [DATA_W-1:0] r_tok_data;
  logic [GEN_W-1:0]  r_tok_gen;
  logic [NODE_W-1:0] r_tok_node;
  logic              r_tok_lr;
  logic              r_tok_uni;
  logic              r_tok_pe_out;
  logic [2:0]        r_tok_pe_num;
  logic              r_cp;
  logic [NODE_W-1:0] r_f_node;
  logic              r_f_lr;
  logic              r_f_uni;
  logic              r_term;
  logic [15:0]       r_tok_cnt;

  bundle_t w_in_bundle;
  bundle_t w_head;
  logic    w_full;
  logic    w_empty;
  logic    w_push;
  logic    w_pop;
  logic    w_hs;
  logic    w_to_f;
  logic    w_advance;

  always_comb begin
    w_in_bundle        = '0;
    w_in_bundle.opr0   = opr0_i;
    w_in_bundle.gen    = gen_i;
    w_in_bundle.t_lr   = t_next_lr_i;
    w_in_bundle.t_uni  = t_next_uni_opr_i;
    w_in_bundle.t_node = t_next_node_i;
    w_in_bundle.f_lr   = f_next_lr_i;
    w_in_bundle.f_uni  = f_next_uni_opr_i;
    w_in_bundle.f_node = f_next_node_i;
    w_in_bundle.cp     = cp_i;
    w_in_bundle.term   = terminate_i;
    w_in_bundle.pe_out = pe_out_i;
    w_in_bundle.pe_num = pe_num_i;
  end

  assign w_head  = r_mem[r_rd_ptr];
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // Push is gated on the registered full flag, so a pop cannot open a slot
  // for the same cycle.
  assign w_push  = in_valid_i && !w_full;

  assign w_hs      = r_tok_valid && tok_ready_i;
  assign w_to_f    = (r_state == EMIT_T) && r_cp && w_hs;
  assign w_advance = (r_state == IDLE) || (w_hs && !w_to_f);
  assign w_pop     = w_advance && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_bundle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_tok_valid  <= 1'b0;
      r_tok_data   <= '0;
      r_tok_gen    <= '0;
      r_tok_node   <= '0;
      r_tok_lr     <= 1'b0;
      r_tok_uni    <= 1'b0;
      r_tok_pe_out <= 1'b0;
      r_tok_pe_num <= '0;
      r_cp         <= 1'b0;
      r_f_node     <= '0;
      r_f_lr       <= 1'b0;
      r_f_uni      <= 1'b0;
      r_term       <= 1'b0;
      r_tok_cnt    <= '0;
    end else begin
      r_term <= 1'b0;
      if (w_hs) r_tok_cnt <= r_tok_cnt + 16'd1;
      if (w_to_f) begin
        r_state    <= EMIT_F;
        r_tok_node <= r_f_node;
        r_tok_lr   <= r_f_lr;
        r_tok_uni  <= r_f_uni;
      end else if (w_advance) begin
        if (w_empty) begin
          r_state     <= IDLE;
          r_tok_valid <= 1'b0;
        end else if (w_head.term) begin
          // Terminate wins over copy: consume the bundle, pulse, emit nothing.
          r_term      <= 1'b1;
          r_state     <= IDLE;
          r_tok_valid <= 1'b0;
        end else begin
          r_state      <= EMIT_T;
          r_tok_valid  <= 1'b1;
          r_tok_data   <= w_head.opr0;
          r_tok_gen    <= w_head.gen;
          r_tok_node   <= w_head.t_node;
          r_tok_lr     <= w_head.t_lr;
          r_tok_uni    <= w_head.t_uni;
          r_tok_pe_out <= w_head.pe_out;
          r_tok_pe_num <= w_head.pe_num;
          r_cp         <= w_head.cp;
          r_f_node     <= w_head.f_node;
          r_f_lr       <= w_head.f_lr;
          r_f_uni      <= w_head.f_uni;
        end
      end
    end
  end

  assign in_ready_o    = !w_full;
  assign tok_valid_o   = r_tok_valid;
  assign tok_data_o    = r_tok_data;
  assign tok_gen_o     = r_tok_gen;
  assign tok_node_o    = r_tok_node;
  assign tok_lr_o      = r_tok_lr;
  assign tok_uni_opr_o = r_tok_uni;
  assign tok_pe_out_o  = r_tok_pe_out;
  assign tok_pe_num_o  = r_tok_pe_num;
  assign term_o        = r_term;
  assign busy_o        = !w_empty || (r_state != IDLE);
  assign tok_cnt_o     = r_tok_cnt;

endmodule

// File: tb/tb_res_token_emitter.sv
// Directed bench for res_token_emitter: hand-computed expectations for
// single, copy, terminate, back-pressure, reset and counter-wrap cases.
module tb_res_token_emitter;

  localparam int DATA_W = 32;
  localparam int GEN_W  = 12;
  localparam int NODE_W = 16;

  logic              clk;
  logic              rst_n;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] opr0_i;
  logic [GEN_W-1:0]  gen_i;
  logic              t_next_lr_i;
  logic              t_next_uni_opr_i;
  logic [NODE_W-1:0] t_next_node_i;
  logic              f_next_lr_i;
  logic              f_next_uni_opr_i;
  logic [NODE_W-1:0] f_next_node_i;
  logic              cp_i;
  logic              terminate_i;
  logic              pe_out_i;
  logic [2:0]        pe_num_i;
  logic              tok_valid_o;
  logic              tok_ready_i;
  logic [DATA_W-1:0] tok_data_o;
  logic [GEN_W-1:0]  tok_gen_o;
  logic [NODE_W-1:0] tok_node_o;
  logic              tok_lr_o;
  logic              tok_uni_opr_o;
  logic              tok_pe_out_o;
  logic [2:0]        tok_pe_num_o;
  logic              term_o;
  logic              busy_o;
  logic [15:0]       tok_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  res_token_emitter #(
    .DEPTH(2), .DATA_W(DATA_W), .GEN_W(GEN_W), .NODE_W(NODE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .opr0_i(opr0_i), .gen_i(gen_i),
    .t_next_lr_i(t_next_lr_i), .t_next_uni_opr_i(t_next_uni_opr_i),
    .t_next_node_i(t_next_node_i),
    .f_next_lr_i(f_next_lr_i), .f_next_uni_opr_i(f_next_uni_opr_i),
    .f_next_node_i(f_next_node_i),
    .cp_i(cp_i), .terminate_i(terminate_i),
    .pe_out_i(pe_out_i), .pe_num_i(pe_num_i),
    .tok_valid_o(tok_valid_o), .tok_ready_i(tok_ready_i),
    .tok_data_o(tok_data_o), .tok_gen_o(tok_gen_o), .tok_node_o(tok_node_o),
    .tok_lr_o(tok_lr_o), .tok_uni_opr_o(tok_uni_opr_o),
    .tok_pe_out_o(tok_pe_out_o), .tok_pe_num_o(tok_pe_num_o),
    .term_o(term_o), .busy_o(busy_o), .tok_cnt_o(tok_cnt_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one bundle for exactly one cycle; returns on the following negedge.
  task automatic put_bundle(input logic [31:0] d, input logic [11:0] g,
                            input logic [15:0] tn, input logic tlr,
                            input logic [15:0] fn, input logic flr,
                            input logic cp, input logic term);
    opr0_i        = d;
    gen_i         = g;
    t_next_node_i = tn;
    t_next_lr_i   = tlr;
    f_next_node_i = fn;
    f_next_lr_i   = flr;
    cp_i          = cp;
    terminate_i   = term;
    in_valid_i    = 1'b1;
    @(negedge clk);
    in_valid_i    = 1'b0;
  endtask

  initial begin
    int pushed;
    int waited;
    in_valid_i = 0; opr0_i = '0; gen_i = '0;
    t_next_lr_i = 0; t_next_uni_opr_i = 0; t_next_node_i = '0;
    f_next_lr_i = 0; f_next_uni_opr_i = 0; f_next_node_i = '0;
    cp_i = 0; terminate_i = 0; pe_out_i = 0; pe_num_i = '0;
    tok_ready_i = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tok_valid", tok_valid_o, 0);
    check("rst_in_ready", in_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_cnt", tok_cnt_o, 0);
    check("rst_term", term_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single bundle, cp=0
    pe_out_i = 1'b1; pe_num_i = 3'd5; t_next_uni_opr_i = 1'b1;
    put_bundle(32'h0000_00A5, 12'h003, 16'h0102, 1'b0, 16'h0F0F, 1'b1, 1'b0, 1'b0);
    check("t1_lat_valid", tok_valid_o, 0);
    check("t1_busy_queued", busy_o, 1);
    @(negedge clk);
    check("t1_valid", tok_valid_o, 1);
    check("t1_data", tok_data_o, 32'h0000_00A5);
    check("t1_gen", tok_gen_o, 12'h003);
    check("t1_node", tok_node_o, 16'h0102);
    check("t1_lr", tok_lr_o, 0);
    check("t1_uni", tok_uni_opr_o, 1);
    check("t1_pe_out", tok_pe_out_o, 1);
    check("t1_pe_num", tok_pe_num_o, 5);
    @(negedge clk);
    check("t1_valid_drop", tok_valid_o, 0);
    check("t1_cnt", tok_cnt_o, 1);
    check("t1_busy_fall", busy_o, 0);
    pe_out_i = 1'b0; pe_num_i = 3'd0; t_next_uni_opr_i = 1'b0;

    // Copy bundle: true token then false token
    put_bundle(32'h1234_5678, 12'h0AB, 16'h0011, 1'b0, 16'h0022, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("t2_t_valid", tok_valid_o, 1);
    check("t2_t_node", tok_node_o, 16'h0011);
    check("t2_t_lr", tok_lr_o, 0);
    check("t2_t_data", tok_data_o, 32'h1234_5678);
    @(negedge clk);
    check("t2_f_valid", tok_valid_o, 1);
    check("t2_f_node", tok_node_o, 16'h0022);
    check("t2_f_lr", tok_lr_o, 1);
    check("t2_f_data", tok_data_o, 32'h1234_5678);
    check("t2_f_gen", tok_gen_o, 12'h0AB);
    @(negedge clk);
    check("t2_valid_drop", tok_valid_o, 0);
    check("t2_cnt", tok_cnt_o, 3);

    // Terminate with cp=1: no token, single pulse
    put_bundle(32'hDEAD_BEEF, 12'h111, 16'h0033, 1'b0, 16'h0044, 1'b0, 1'b1, 1'b1);
    check("t3_term_early", term_o, 0);
    @(negedge clk);
    check("t3_term_pulse", term_o, 1);
    check("t3_no_tok", tok_valid_o, 0);
    @(negedge clk);
    check("t3_term_end", term_o, 0);
    check("t3_no_tok2", tok_valid_o, 0);
    check("t3_cnt", tok_cnt_o, 3);

    // Back-to-back terminates: consecutive pulses
    put_bundle(32'h1, 12'h1, 16'h1, 1'b0, 16'h1, 1'b0, 1'b0, 1'b1);
    put_bundle(32'h2, 12'h2, 16'h2, 1'b0, 16'h2, 1'b0, 1'b0, 1'b1);
    check("t3b_pulse1", term_o, 1);
    @(negedge clk);
    check("t3b_pulse2", term_o, 1);
    @(negedge clk);
    check("t3b_pulse_end", term_o, 0);

    // Token followed by terminate while emitting
    put_bundle(32'h0000_7777, 12'h077, 16'h0707, 1'b1, 16'h0808, 1'b0, 1'b0, 1'b0);
    put_bundle(32'h0, 12'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("t3c_valid", tok_valid_o, 1);
    check("t3c_data", tok_data_o, 32'h0000_7777);
    check("t3c_term_low", term_o, 0);
    @(negedge clk);
    check("t3c_valid_drop", tok_valid_o, 0);
    check("t3c_term", term_o, 1);
    check("t3c_cnt", tok_cnt_o, 4);

    // Back-pressure: three bundles, DEPTH=2
    tok_ready_i = 1'b0;
    put_bundle(32'hB1, 12'h0B1, 16'h00B1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    put_bundle(32'hB2, 12'h0B2, 16'h00B2, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    put_bundle(32'hB3, 12'h0B3, 16'h00B3, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check("t4_full", in_ready_o, 0);
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", tok_valid_o, 1);
      check("t4_hold_data", tok_data_o, 32'hB1);
      check("t4_hold_node", tok_node_o, 16'h00B1);
      @(negedge clk);
    end
    check("t4_still_full", in_ready_o, 0);
    // Offer a fourth bundle on the release cycle: must be refused.
    tok_ready_i = 1'b1;
    opr0_i = 32'hB4; gen_i = 12'h0B4; t_next_node_i = 16'h00B4;
    cp_i = 1'b0; terminate_i = 1'b0; in_valid_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    check("t4_tok2_valid", tok_valid_o, 1);
    check("t4_tok2_data", tok_data_o, 32'hB2);
    check("t4_tok2_gen", tok_gen_o, 12'h0B2);
    @(negedge clk);
    check("t4_tok3_valid", tok_valid_o, 1);
    check("t4_tok3_data", tok_data_o, 32'hB3);
    @(negedge clk);
    check("t4_no_push_through", tok_valid_o, 0);
    check("t4_busy", busy_o, 0);
    check("t4_cnt", tok_cnt_o, 7);

    // Reset during EMIT_F with one FIFO entry
    tok_ready_i = 1'b0;
    put_bundle(32'hCAFE_0001, 12'h055, 16'h0A0A, 1'b0, 16'h0B0B, 1'b1, 1'b1, 1'b0);
    put_bundle(32'hCAFE_0002, 12'h056, 16'h0C0C, 1'b0, 16'h0D0D, 1'b0, 1'b0, 1'b0);
    check("t5_t_node", tok_node_o, 16'h0A0A);
    tok_ready_i = 1'b1;
    @(negedge clk);
    tok_ready_i = 1'b0;
    check("t5_f_valid", tok_valid_o, 1);
    check("t5_f_node", tok_node_o, 16'h0B0B);
    check("t5_cnt_pre", tok_cnt_o, 8);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", tok_valid_o, 0);
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_cnt", tok_cnt_o, 0);
    check("t5_rst_in_ready", in_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tok_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_stale", tok_valid_o, 0);
    end
    check("t5_busy_after", busy_o, 0);

    // 65536 tokens: counter wraps to zero
    opr0_i = 32'h5A5A; gen_i = 12'h5A; t_next_node_i = 16'h0505;
    cp_i = 1'b0; terminate_i = 1'b0; in_valid_i = 1'b1;
    pushed = 0;
    while (pushed < 65536) begin
      if (in_ready_o) pushed++;
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    waited = 0;
    while (busy_o && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("t6_drain", busy_o, 0);
    check("t6_wrap", tok_cnt_o, 16'h0000);
    put_bundle(32'h9, 12'h9, 16'h0009, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("t6_after_wrap", tok_cnt_o, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
